vga_timing: RTL
===============

# vga_timing

Parametrised VGA raster timing generator, the successor to the fixed 640x480 sync generator. It adds:
- compile-time resolution and porch/sync parameters, sync polarity and colour depth;
- a pixel-clock enable, so it can run from a faster system clock;
- a configurable pixel-source latency, so externally fetched RGB lines up with the syncs;
- a data-enable output, blanked RGB, and line/frame start strobes.

It sits between the frame/pattern source, which consumes `x_o`/`y_o`, and the VGA connector pins.

## Interface
Parameters:
- `BPC`, 4: bits per colour channel.
- `CNT_W`, 10: counter and coordinate width; must hold `H_TOTAL-1` and `V_TOTAL-1`.
- `H_VIS`, `H_FP`, `H_SYNC`, `H_BP`, defaults 640, 16, 96, 48: horizontal timing in pixel ticks. `H_TOTAL` is their sum.
- `V_VIS`, `V_FP`, `V_SYNC`, `V_BP`, defaults 480, 10, 2, 33: vertical timing in lines. `V_TOTAL` is their sum.
- `HS_POL`, 0: active level of `hsync_o`.
- `VS_POL`, 0: active level of `vsync_o`.
- `LAT`, 0: pixel-source latency in ticks, range 0..7.

Ports:
- `clk_i` in 1: system clock.
- `reset_ni` in 1: reset, synchronous and active-low.
- `pix_en_i` in 1: pixel tick enable. Tie to 1 when `clk_i` is the pixel clock.
- `x_o` out CNT_W: current horizontal counter, combinational from the register.
- `y_o` out CNT_W: current vertical counter, combinational from the register.
- `req_o` out 1: `x_o`/`y_o` lie in the visible area (`x<H_VIS && y<V_VIS`).
- `red_i`, `green_i`, `blue_i` in BPC each: pixel for the position requested `LAT` ticks earlier.
- `red_o`, `green_o`, `blue_o` out BPC each: colour to the DAC.
- `hsync_o`, `vsync_o` out 1: sync outputs.
- `de_o` out 1: output pixel is visible.
- `line_start_o` out 1: output pixel has x=0.
- `frame_start_o` out 1: output pixel is (0,0).

## Operation
- **Tick:** a tick is a `clk_i` edge with `pix_en_i=1`. All state updates only on ticks. Outputs hold between ticks.
- **Counters:**
  - h advances 0..`H_TOTAL-1` and wraps to 0. On the wrap, v increments.
  - v wraps from `V_TOTAL-1` to 0 on the same tick that h wraps.
- **Raw signals**, decoded combinationally from the counters:
  - hs active iff `H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC`.
  - vs active iff `V_VIS+V_FP <= v < V_VIS+V_FP+V_SYNC`. It is line-granular and switches when h wraps.
  - de = `req_o`; ls = (h==0); fs = (h==0 && v==0).
- **Alignment:**
  - hs/vs/de/ls/fs pass through a `LAT`-stage tick-enabled delay line, then one output register.
  - RGB is sampled into the output register on the tick when the delayed de arrives. It is forced to 0 when the delayed de=0.
  - Net effect: all outputs describing position P appear together `LAT+1` ticks after P was on `x_o`/`y_o`.
- **Sync polarity:** `hsync_o = HS_POL ? hs : ~hs`. `vsync_o` likewise with `VS_POL`.
- **Reset** (sampled on any `clk_i` edge, regardless of `pix_en_i`):
  - h=0, v=0, all delay stages cleared.
  - `hsync_o`=`~HS_POL`, `vsync_o`=`~VS_POL`.
  - `de_o`, `line_start_o`, `frame_start_o` and RGB = 0.
  - `x_o`=`y_o`=0 and `req_o`=1 immediately after reset.
  - Reset mid-frame abandons the frame. The first tick after release starts a new frame at (0,0).
- **Arithmetic:** all comparisons are unsigned CNT_W bit. Parameter sums are evaluated at elaboration; no runtime arithmetic beyond the +1 counters.

## Timing
- `x_o`, `y_o`, `req_o`: valid in the same cycle the counters update. They are combinational from registers and carry no input-to-output path.
- Outputs: latency from position P to outputs is `LAT+1` ticks. With `LAT=0`, RGB is sampled the same tick P is presented.
- Frame start:
  - `frame_start_o` first asserts on the `(LAT+1)`th tick after reset release.
  - It repeats every `H_TOTAL*V_TOTAL` ticks.
  - Each pulse lasts exactly one tick.
- Horizontal sync: `hsync_o` active for `H_SYNC` consecutive ticks per line.
- Vertical sync: `vsync_o` active for exactly `V_SYNC*H_TOTAL` ticks per frame. It is asserted and released together with a line-start tick.
- `pix_en_i=0` for any number of cycles freezes every register. Nothing is skipped or duplicated.

## Structure
- **Shared package `vga_pkg`:**
  - Timing constant sets `VGA_640x480_60` (25.175 MHz) and `VGA_800x600_60` (40 MHz: 800/40/128/88, 600/1/4/23 with positive polarity).
  - A `clog2`-based width helper.
- **Sub-module `vga_delay`:** parametrised width × depth shift register with enable and synchronous clear. At depth 0 it is a wire. It is instantiated once for the 5-bit {hs, vs, de, ls, fs} bundle.

## Test plan
- **Reset values:** assert `reset_ni=0` for 3 cycles with `pix_en_i=1`, defaults.
  - Required: `hsync_o`=`vsync_o`=1, `de_o`=0, RGB=0, `x_o`=`y_o`=0 while held.
  - Required: `frame_start_o`=1 on the first tick after release.
- **Full frame, defaults:** run 2 frames.
  - Required: `frame_start_o` period 420000 ticks.
  - Required: `hsync_o` low for 96 ticks, beginning 656 ticks after each `line_start_o`.
  - Required: `vsync_o` low for 1600 ticks, starting at line 490.
  - Required: 307200 `de_o` ticks per frame.
- **Latency alignment:** `LAT=3`, source returns `red=x[3:0]`, `green=y[3:0]` delayed by 3 ticks.
  - Required: each `de_o` tick shows `red_o` equal to the `de_o`-tick count within the line mod 16, and `green_o` equal to the line mod 16.
  - Required: RGB=0 whenever `de_o`=0, even with the source held at F.
- **Clock enable:** `pix_en_i` toggles 1,0,1,0.
  - Required: frame period 840000 cycles.
  - Required: outputs change only on cycles following an enabled edge.
  - Required: the counter sequence is identical to the `pix_en_i=1` run.
- **Wrap boundary:** drive to h=799, v=524.
  - Required: the next tick gives (0,0) and `frame_start_o` pulses `LAT+1` ticks later.
  - Required: with 800x600 parameters and positive polarity, `vsync_o` is high for 4 lines at lines 601..604.
- **Reset mid-frame:** assert reset at (300,200) for 1 cycle with `pix_en_i=0`.
  - Required: reset still takes effect and counters read (0,0).
  - Required: no stale de/sync emerges from the delay line afterwards.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing mode sets, raw sync bundle type and width helper
package vga_pkg;

  // One complete raster mode: pixel clock, horizontal/vertical geometry, sync polarity
  typedef struct packed {
    int unsigned pclk_khz;
    int unsigned h_vis;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_vis;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    bit          hs_pol;
    bit          vs_pol;
  } vga_mode_t;

  localparam vga_mode_t VGA_640x480_60 = '{
    pclk_khz: 25175,
    h_vis: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_vis: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    hs_pol: 1'b0, vs_pol: 1'b0
  };

  localparam vga_mode_t VGA_800x600_60 = '{
    pclk_khz: 40000,
    h_vis: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_vis: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
    hs_pol: 1'b1, vs_pol: 1'b1
  };

  // Position-derived signals that travel down the latency-matching delay line
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic ls;
    logic fs;
  } vga_raw_t;

  // Counter width able to hold 0..total-1
  function automatic int cnt_width(input int unsigned total);
    return (total <= 1) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - pixel request/return bundle between timing generator and pixel source
interface vga_timing_if #(
  parameter int CNT_W = 10,
  parameter int BPC   = 4
);

  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             req;
  logic [BPC-1:0]   red;
  logic [BPC-1:0]   green;
  logic [BPC-1:0]   blue;

  // Timing generator drives the position, the pixel source answers with colour
  modport master (output x, y, req, input red, green, blue);
  modport slave  (input x, y, req, output red, green, blue);

endinterface

// File: rtl/vga_delay.sv
// rtl/vga_delay.sv - width x depth shift register with tick enable and synchronous clear
module vga_delay #(
  parameter int W = 1,
  parameter int D = 0
) (
  input  logic         clk,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (D == 0) begin : g_wire
    assign q = d;
    // Depth zero needs no state; keep the control pins referenced
    logic unused;
    assign unused = &{1'b0, clk, en, clr};
  end else begin : g_shift
    logic [W-1:0] stage [D];

    // Shift one stage per tick; clear wins over enable so reset never waits for a tick
    always_ff @(posedge clk) begin
      if (clr) begin
        for (int i = 0; i < D; i++) stage[i] <= '0;
      end else if (en) begin
        stage[0] <= d;
        for (int i = 1; i < D; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[D-1];
  end

endmodule

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - parametrised VGA raster timing generator with pixel enable and source latency
module vga_timing
  import vga_pkg::*;
#(
  parameter int BPC    = 4,
  parameter int CNT_W  = 10,
  parameter int H_VIS  = VGA_640x480_60.h_vis,
  parameter int H_FP   = VGA_640x480_60.h_fp,
  parameter int H_SYNC = VGA_640x480_60.h_sync,
  parameter int H_BP   = VGA_640x480_60.h_bp,
  parameter int V_VIS  = VGA_640x480_60.v_vis,
  parameter int V_FP   = VGA_640x480_60.v_fp,
  parameter int V_SYNC = VGA_640x480_60.v_sync,
  parameter int V_BP   = VGA_640x480_60.v_bp,
  parameter bit HS_POL = VGA_640x480_60.hs_pol,
  parameter bit VS_POL = VGA_640x480_60.vs_pol,
  parameter int LAT    = 0
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             pix_en_i,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic             req_o,
  input  logic [BPC-1:0]   red_i,
  input  logic [BPC-1:0]   green_i,
  input  logic [BPC-1:0]   blue_i,
  output logic [BPC-1:0]   red_o,
  output logic [BPC-1:0]   green_o,
  output logic [BPC-1:0]   blue_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             de_o,
  output logic             line_start_o,
  output logic             frame_start_o
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  // All boundaries folded to counter width at elaboration
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_VIS + V_FP + V_SYNC);

  logic [CNT_W-1:0] h;
  logic [CNT_W-1:0] v;
  vga_raw_t         raw;
  vga_raw_t         dly;

  // Raster counters: h runs across the line, v steps on the h wrap and wraps with it
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      h <= '0;
      v <= '0;
    end else if (pix_en_i) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  assign x_o   = h;
  assign y_o   = v;
  assign req_o = (h < H_ACT) && (v < V_ACT);

  // Decode the position into sync/enable/strobe levels (active-high internally)
  always_comb begin
    raw    = '0;
    raw.hs = (h >= HS_BEG) && (h < HS_END);
    raw.vs = (v >= VS_BEG) && (v < VS_END);
    raw.de = req_o;
    raw.ls = (h == '0);
    raw.fs = (h == '0) && (v == '0);
  end

  // Hold the decoded levels back until the externally fetched pixel returns
  vga_delay #(
    .W ($bits(vga_raw_t)),
    .D (LAT)
  ) u_delay (
    .clk (clk_i),
    .en  (pix_en_i),
    .clr (!reset_ni),
    .d   (raw),
    .q   (dly)
  );

  // Output register: applies polarity and blanks the colour outside the visible area
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      hsync_o       <= ~HS_POL;
      vsync_o       <= ~VS_POL;
      de_o          <= 1'b0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
      red_o         <= '0;
      green_o       <= '0;
      blue_o        <= '0;
    end else if (pix_en_i) begin
      hsync_o       <= HS_POL ? dly.hs : ~dly.hs;
      vsync_o       <= VS_POL ? dly.vs : ~dly.vs;
      de_o          <= dly.de;
      line_start_o  <= dly.ls;
      frame_start_o <= dly.fs;
      red_o         <= dly.de ? red_i   : '0;
      green_o       <= dly.de ? green_i : '0;
      blue_o        <= dly.de ? blue_i  : '0;
    end
  end

endmodule
